// File: rtl/mem_fill_pkg.sv
// Shared types for the memory fill engine: controller states and fill modes.
package mem_fill_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_IDENTITY   = 2'd0,
    MODE_CONST      = 2'd1,
    MODE_COMPLEMENT = 2'd2,
    MODE_STEP       = 2'd3
  } mode_t;

endpackage

// File: rtl/fill_datagen.sv
// Write-data generator: decodes the latched fill mode and keeps the STEP
// accumulator, so wrdata depends only on registered state.
module fill_datagen
  import mem_fill_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] pattern,
  input  logic [DATA_W-1:0] step,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wrdata
);

  localparam int WIDE_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

  mode_t             mode_e;
  logic [WIDE_W-1:0] addr_wide;
  logic [DATA_W-1:0] id_val;
  logic [DATA_W-1:0] offset;

  assign mode_e    = mode_t'(mode);
  assign addr_wide = WIDE_W'(addr);
  assign id_val    = addr_wide[DATA_W-1:0];

  // Running k*step offset; cleared when a fill is accepted, bumped per non-final write.
  always_ff @(posedge clk) begin
    if (rst) begin
      offset <= '0;
    end else if (load) begin
      offset <= '0;
    end else if (advance) begin
      offset <= offset + step;
    end else begin
      offset <= offset;
    end
  end

  always_comb begin
    wrdata = id_val;
    case (mode_e)
      MODE_IDENTITY:   wrdata = id_val;
      MODE_CONST:      wrdata = pattern;
      MODE_COMPLEMENT: wrdata = ~id_val;
      MODE_STEP:       wrdata = pattern + offset;
      default:         wrdata = id_val;
    endcase
  end

endmodule

// File: rtl/mem_fill.sv
// Memory fill engine: writes one generated word per cycle over an inclusive,
// wrapping address range, with abort and a one-cycle completion pulse.
module mem_fill
  import mem_fill_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              rdy,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [DATA_W-1:0] pattern,
  input  logic [DATA_W-1:0] step,
  input  logic              abort,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wrdata,
  output logic              wren,
  output logic              done,
  output logic [ADDR_W:0]   count
);

  state_t            state;
  logic [ADDR_W-1:0] end_l;
  logic [1:0]        mode_l;
  logic [DATA_W-1:0] pattern_l;
  logic [DATA_W-1:0] step_l;
  logic              accept;
  logic              last;
  logic              advance;

  assign rdy     = (state == IDLE);
  assign wren    = (state == FILL);
  assign done    = (state == DONE);
  assign accept  = rdy & en;
  assign last    = (addr == end_l);
  // Address (and STEP offset) stay put on the final or aborted write so they hold afterwards.
  assign advance = wren & ~last & ~abort;

  // Controller: accept, address walk, end compare, word count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      count     <= '0;
      end_l     <= '0;
      mode_l    <= MODE_IDENTITY;
      pattern_l <= '0;
      step_l    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state     <= FILL;
            addr      <= start_addr;
            end_l     <= end_addr;
            mode_l    <= mode;
            pattern_l <= pattern;
            step_l    <= step;
            count     <= '0;
          end
        end
        FILL: begin
          count <= count + (ADDR_W + 1)'(1);
          if (abort) begin
            state <= IDLE;
          end else if (last) begin
            state <= DONE;
          end else begin
            addr <= addr + ADDR_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  fill_datagen #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_datagen (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .advance(advance),
    .mode   (mode_l),
    .pattern(pattern_l),
    .step   (step_l),
    .addr   (addr),
    .wrdata (wrdata)
  );

endmodule

// File: tb/tb_mem_fill.sv
// Self-checking bench for mem_fill: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, randomized traffic.
module tb_mem_fill;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, abort;
  logic [1:0] mode;
  logic [7:0] start_addr, end_addr, pattern, step;
  logic       rdy, wren, done;
  logic [7:0] addr, wrdata;
  logic [8:0] count;

  logic       s_en;
  logic [3:0] s_start, s_end;
  logic       s_rdy, s_wren, s_done;
  logic [3:0] s_addr;
  logic [7:0] s_wrdata;
  logic [4:0] s_count;

  mem_fill #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .mode(mode),
    .start_addr(start_addr), .end_addr(end_addr), .pattern(pattern), .step(step),
    .abort(abort), .addr(addr), .wrdata(wrdata), .wren(wren), .done(done), .count(count)
  );

  mem_fill #(.ADDR_W(4), .DATA_W(8)) dut_s (
    .clk(clk), .rst(rst), .en(s_en), .rdy(s_rdy), .mode(mode),
    .start_addr(s_start), .end_addr(s_end), .pattern(pattern), .step(step),
    .abort(abort), .addr(s_addr), .wrdata(s_wrdata), .wren(s_wren), .done(s_done), .count(s_count)
  );

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a fill is a list of (addr,data) writes computed up front.
  typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
  wr_t        q[$];
  bit         m_rdy = 1'b1, m_wren = 1'b0, m_done = 1'b0;
  logic [7:0] m_addr = 8'd0, m_data = 8'd0;
  int         m_count = 0;

  task automatic model_step();
    int   n;
    wr_t  w;
    if (rst) begin
      q.delete();
      m_rdy = 1'b1; m_wren = 1'b0; m_done = 1'b0;
      m_addr = 8'd0; m_data = 8'd0; m_count = 0;
    end else if (m_wren) begin
      m_count++;
      void'(q.pop_front());
      if (abort) begin
        q.delete();
        m_wren = 1'b0; m_rdy = 1'b1;
      end else if (q.size() == 0) begin
        m_wren = 1'b0; m_done = 1'b1;
      end else begin
        m_addr = q[0].a; m_data = q[0].d;
      end
    end else if (m_done) begin
      m_done = 1'b0; m_rdy = 1'b1;
    end else if (en) begin
      n = ((int'(end_addr) - int'(start_addr) + 256) % 256) + 1;
      for (int k = 0; k < n; k++) begin
        w.a = 8'((int'(start_addr) + k) % 256);
        case (mode)
          2'd0:    w.d = w.a;
          2'd1:    w.d = pattern;
          2'd2:    w.d = ~w.a;
          default: w.d = 8'(int'(pattern) + k * int'(step));
        endcase
        q.push_back(w);
      end
      m_count = 0; m_rdy = 1'b0; m_wren = 1'b1;
      m_addr = q[0].a; m_data = q[0].d;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Per-cycle compare plus write/done monitors for the directed scenarios.
  logic [7:0] log_a[$], log_d[$], s_log_d[$];
  int         done_cnt = 0, s_done_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("rdy", rdy, m_rdy);
        chk("wren", wren, m_wren);
        chk("done", done, m_done);
        chk("addr", addr, m_addr);
        chk("wrdata", wrdata, m_data);
        chk("count", count, m_count);
      end
      if (wren === 1'b1) begin log_a.push_back(addr); log_d.push_back(wrdata); end
      if (done === 1'b1) done_cnt++;
      if (s_wren === 1'b1) s_log_d.push_back(s_wrdata);
      if (s_done === 1'b1) s_done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic wait_rdy();
    int n = 0;
    while (rdy !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    if (rdy !== 1'b1) chk("wait_rdy_timeout", 32'd0, 32'd1);
  endtask

  task automatic start_fill(input logic [1:0] m, input logic [7:0] s, input logic [7:0] e,
                            input logic [7:0] p, input logic [7:0] st);
    wait_rdy();
    log_a.delete(); log_d.delete();
    mode = m; start_addr = s; end_addr = e; pattern = p; step = st; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask

  logic [7:0] exp039[10];
  int d0;

  initial begin
    rst = 1'b1; en = 1'b0; abort = 1'b0; mode = 2'd0;
    start_addr = 8'd0; end_addr = 8'd0; pattern = 8'd0; step = 8'd0;
    s_en = 1'b0; s_start = 4'd0; s_end = 4'd0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_rdy", rdy, 32'd1);
    chk("reset_wren", wren, 32'd0);
    chk("reset_done", done, 32'd0);
    chk("reset_addr", addr, 32'd0);
    chk("reset_wrdata", wrdata, 32'd0);
    chk("reset_count", count, 32'd0);
    chk("reset_s_count", s_count, 32'd0);
    chk_on = 1'b1;
    rst = 1'b0;

    // Full-range identity fill
    d0 = done_cnt;
    start_fill(2'd0, 8'd0, 8'd255, 8'd0, 8'd0);
    wait_rdy();
    chk("full_nwrites", log_a.size(), 32'd256);
    for (int i = 0; i < 256 && i < log_a.size(); i++) begin
      if (log_a[i] !== 8'(i) || log_d[i] !== 8'(i)) chk("full_seq", {log_a[i], log_d[i]}, {8'(i), 8'(i)});
    end
    chk("full_count", count, 32'd256);
    chk("full_done_pulses", done_cnt - d0, 32'd1);

    // Wrapping CONST fill
    exp039 = '{8'd250, 8'd251, 8'd252, 8'd253, 8'd254, 8'd255, 8'd0, 8'd1, 8'd2, 8'd3};
    start_fill(2'd1, 8'd250, 8'd3, 8'hA5, 8'd0);
    wait_rdy();
    chk("wrap_nwrites", log_a.size(), 32'd10);
    for (int i = 0; i < 10 && i < log_a.size(); i++) begin
      chk("wrap_addr", log_a[i], exp039[i]);
      chk("wrap_data", log_d[i], 32'hA5);
    end
    chk("wrap_count", count, 32'd10);

    // STEP: single word, then three words
    start_fill(2'd3, 8'd7, 8'd7, 8'h10, 8'h03);
    wait_rdy();
    chk("step1_nwrites", log_a.size(), 32'd1);
    if (log_a.size() > 0) begin
      chk("step1_addr", log_a[0], 32'd7);
      chk("step1_data", log_d[0], 32'h10);
    end
    chk("step1_count", count, 32'd1);
    start_fill(2'd3, 8'd0, 8'd2, 8'h10, 8'h03);
    wait_rdy();
    chk("step3_nwrites", log_d.size(), 32'd3);
    if (log_d.size() == 3) begin
      chk("step3_d0", log_d[0], 32'h10);
      chk("step3_d1", log_d[1], 32'h13);
      chk("step3_d2", log_d[2], 32'h16);
    end

    // Abort on the 5th write cycle
    d0 = done_cnt;
    start_fill(2'd0, 8'd0, 8'd255, 8'd0, 8'd0);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_rdy", rdy, 32'd1);
    wait_rdy();
    chk("abort_nwrites", log_a.size(), 32'd5);
    for (int i = 0; i < 5 && i < log_a.size(); i++) chk("abort_addr", log_a[i], 32'(i));
    chk("abort_count", count, 32'd5);
    chk("abort_done_pulses", done_cnt - d0, 32'd0);

    // Reset on the 3rd FILL cycle, en pulsed during FILL
    d0 = done_cnt;
    start_fill(2'd0, 8'd0, 8'd255, 8'd0, 8'd0);
    start_addr = 8'd99; end_addr = 8'd99; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_rdy", rdy, 32'd1);
    chk("rst_wren", wren, 32'd0);
    chk("rst_count", count, 32'd0);
    chk("rst_nwrites", log_a.size(), 32'd3);
    chk("rst_done_pulses", done_cnt - d0, 32'd0);

    // Narrow instance: COMPLEMENT over the whole 16-word space
    s_log_d.delete();
    d0 = s_done_cnt;
    mode = 2'd2; s_start = 4'd0; s_end = 4'd15; s_en = 1'b1;
    @(negedge clk);
    s_en = 1'b0;
    for (int n = 0; n < 100 && s_rdy !== 1'b1; n++) @(negedge clk);
    chk("cmp_nwrites", s_log_d.size(), 32'd16);
    for (int i = 0; i < 16 && i < s_log_d.size(); i++) chk("cmp_data", s_log_d[i], 32'(8'hFF - 8'(i)));
    chk("cmp_count", s_count, 32'd16);
    chk("cmp_done_pulses", s_done_cnt - d0, 32'd1);

    // Randomized traffic: requests, aborts, overlapping en, occasional reset
    for (int c = 0; c < 2500; c++) begin
      rst        = ($urandom_range(0, 199) == 0);
      en         = ($urandom_range(0, 3) == 0);
      abort      = ($urandom_range(0, 24) == 0);
      mode       = 2'($urandom_range(0, 3));
      start_addr = 8'($urandom_range(0, 255));
      end_addr   = start_addr + 8'($urandom_range(0, 24));
      pattern    = 8'($urandom_range(0, 255));
      step       = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    rst = 1'b0; en = 1'b0; abort = 1'b0;
    wait_rdy();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
